// File: rtl/video_timing_gen_if.sv
// Raster timing bundle between video_timing_gen (master) and its pixel/encoder consumers (slave).
// The consumer side owns the advance enable; everything else flows from the generator.
interface video_timing_gen_if #(
   parameter int CW = 10
);
   logic          en;
   logic [CW-1:0] sx;
   logic [CW-1:0] sy;
   logic          de;
   logic          hsync;
   logic          vsync;
   logic          line_start;
   logic          frame_start;
   logic [15:0]   frame_count;
   logic          de_d;
   logic          hsync_d;
   logic          vsync_d;

   modport master (
      input  en,
      output sx, sy, de, hsync, vsync, line_start, frame_start, frame_count,
             de_d, hsync_d, vsync_d
   );

   modport slave (
      output en,
      input  sx, sy, de, hsync, vsync, line_start, frame_start, frame_count,
             de_d, hsync_d, vsync_d
   );
endinterface

// File: rtl/video_timing_gen.sv
// Parameterised raster timing generator: coordinates, de/syncs, strobes and delayed controls.
// Define VTG_FRAME_COUNT_EN to build the completed-frame counter; otherwise frame_count reads 0.
module video_timing_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int HS_POL     = 0,
   parameter int VS_POL     = 0,
   parameter int PIPE_DELAY = 2,
   parameter int CW         = 10
) (
   input logic               clk,
   input logic               rst_n,
   video_timing_gen_if.master vif
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic          HS_ON  = (HS_POL != 0);
   localparam logic          VS_ON  = (VS_POL != 0);

   typedef struct packed {
      logic de;
      logic hsync;
      logic vsync;
   } ctl_t;

   localparam ctl_t CTL_IDLE = '{de: 1'b0, hsync: ~HS_ON, vsync: ~VS_ON};

   generate
      if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_delay
         $fatal(1, "video_timing_gen: PIPE_DELAY must be 0..15");
      end
      if (H_TOTAL - 1 >= (1 << CW) || V_TOTAL - 1 >= (1 << CW)) begin : g_bad_width
         $fatal(1, "video_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
      end
   endgenerate

   logic [CW-1:0] sx_q, sy_q, sx_nxt, sy_nxt;
   ctl_t          ctl_q, ctl_nxt;
   logic          line_q, frame_q, frame_hit;

   // Outputs are decoded from the next-state counters so they register alongside sx/sy.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      sx_nxt = sx_q + CW'(1);
      sy_nxt = sy_q;
      if (sx_q == H_LAST) begin
         sx_nxt = '0;
         sy_nxt = (sy_q == V_LAST) ? '0 : sy_q + CW'(1);
      end
      ctl_nxt.de    = (sx_nxt < H_ACT) && (sy_nxt < V_ACT);
      ctl_nxt.hsync = (sx_nxt >= HS_BEG && sx_nxt < HS_END) ? HS_ON : ~HS_ON;
      ctl_nxt.vsync = (sy_nxt >= VS_BEG && sy_nxt < VS_END) ? VS_ON : ~VS_ON;
      frame_hit     = (sx_nxt == '0) && (sy_nxt == '0);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sx_q    <= H_LAST;
         sy_q    <= V_LAST;
         ctl_q   <= CTL_IDLE;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
      end else if (vif.en) begin
         sx_q    <= sx_nxt;
         sy_q    <= sy_nxt;
         ctl_q   <= ctl_nxt;
         line_q  <= (sx_nxt == '0);
         frame_q <= frame_hit;
      end else begin
         line_q  <= 1'b0;
         frame_q <= 1'b0;
      end
   end

   assign vif.sx          = sx_q;
   assign vif.sy          = sy_q;
   assign vif.de          = ctl_q.de;
   assign vif.hsync       = ctl_q.hsync;
   assign vif.vsync       = ctl_q.vsync;
   assign vif.line_start  = line_q;
   assign vif.frame_start = frame_q;

`ifdef VTG_FRAME_COUNT_EN
   logic [15:0] frame_count_q;
   logic        seen_frame_q;

   // The first frame_start after reset opens frame 0, so it does not count as a completed frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_count_q <= '0;
         seen_frame_q  <= 1'b0;
      end else if (vif.en && frame_hit) begin
         if (seen_frame_q) frame_count_q <= frame_count_q + 16'd1;
         seen_frame_q <= 1'b1;
      end
   end

   assign vif.frame_count = frame_count_q;
`else
   assign vif.frame_count = 16'h0000;
`endif

   generate
      if (PIPE_DELAY == 0) begin : g_no_delay
         assign vif.de_d    = ctl_q.de;
         assign vif.hsync_d = ctl_q.hsync;
         assign vif.vsync_d = ctl_q.vsync;
      end else begin : g_delay
         ctl_t pipe_q [PIPE_DELAY];

         // NOTE: the delay stages are reset on purpose so the encoders never see stale control symbols.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= CTL_IDLE;
            end else if (vif.en) begin
               pipe_q[0] <= ctl_q;
               for (int i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end

         assign vif.de_d    = pipe_q[PIPE_DELAY-1].de;
         assign vif.hsync_d = pipe_q[PIPE_DELAY-1].hsync;
         assign vif.vsync_d = pipe_q[PIPE_DELAY-1].vsync;
      end
   endgenerate
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parameterised raster timing generator for the HDMI output path.
- Sits directly upstream of the pixel sources (image generator, shader pipeline) and the three TMDS channel encoders.
- Produces the pixel coordinates and the de/hsync/vsync signals, plus frame/line strobes and a frame counter for animation.
- Also provides copies of de/hsync/vsync delayed by a fixed number of cycles, so the control symbols reaching the encoders line up with colour data from pipelined pixel stages.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync output level while asserted (0 = active-low)
- VS_POL, 0, vsync output level while asserted
- PIPE_DELAY, 2, delay in cycles for the *_d outputs; legal range 0..15
- CW, 10, coordinate width; H_TOTAL-1 and V_TOTAL-1 must fit in CW bits

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst_n  in  1  synchronous reset, active-low
- en  in  1  advance enable; 1 = advance one pixel per clk
- sx  out  CW  horizontal position, 0..H_TOTAL-1
- sy  out  CW  vertical position, 0..V_TOTAL-1
- de  out  1  active video, coherent with sx/sy
- hsync  out  1  horizontal sync, coherent with sx/sy
- vsync  out  1  vertical sync, coherent with sx/sy
- line_start  out  1  one-cycle strobe when sx==0
- frame_start  out  1  one-cycle strobe when sx==0 and sy==0
- frame_count  out  16  completed-frame counter
- de_d  out  1  de delayed by PIPE_DELAY cycles
- hsync_d  out  1  hsync delayed by PIPE_DELAY cycles
- vsync_d  out  1  vsync delayed by PIPE_DELAY cycles

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- All outputs are registered; no combinational path from en to any output.
- Reset (rst_n==0 at a clk edge):
  - sx=H_TOTAL-1, sy=V_TOTAL-1.
  - de=0; hsync=~HS_POL; vsync=~VS_POL.
  - line_start=0, frame_start=0, frame_count=0.
  - Every stage of the delay pipeline is reset to de=0 and inactive sync levels.
- Reset applies mid-frame with the same result; no partial line is completed.
- Counter update when en==1:
  - sx wraps H_TOTAL-1 -> 0; otherwise sx increments.
  - sy increments only when sx wraps; sy wraps V_TOTAL-1 -> 0.
- Coherence: de/hsync/vsync/strobes are decoded from the next-state counter values and registered together with sx/sy. Every output describes the same pixel in the same cycle.
- de = (sx < H_ACTIVE) && (sy < V_ACTIVE).
- hsync is asserted (level HS_POL) for H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751 at defaults.
- vsync is asserted (level VS_POL) for V_ACTIVE+V_FP <= sy < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491 at defaults.
- line_start=1 in the cycle sx==0.
- frame_start=1 in the cycle sx==0 && sy==0.
- frame_count increments by 1 (wrapping modulo 2^16) in the same cycle frame_start rises, except the first frame_start after reset, which leaves it at 0.
- First en cycle after reset: sx=0, sy=0, de=1, line_start=1, frame_start=1, frame_count=0.
- When en==0:
  - sx, sy, de, hsync, vsync and frame_count hold.
  - line_start and frame_start are forced to 0.
  - The delay pipeline holds; it does not shift.
- Delay pipeline: the *_d outputs equal de/hsync/vsync exactly PIPE_DELAY enabled cycles earlier.
  - PIPE_DELAY=0 means *_d are identical to de/hsync/vsync.
  - Out-of-range PIPE_DELAY is an elaboration error.
- Frame period: exactly H_TOTAL*V_TOTAL enabled cycles (420000 at defaults).

Optional Feature:
- Macro: VTG_FRAME_COUNT_EN.
- When defined: frame_count behaves as specified above.
- When undefined: the frame_count register is not built and frame_count is tied to 16'h0000. All other outputs are unchanged.

Test Plan:
- Reset check: hold rst_n=0 for 3 clks with en=1, then release -> during reset sx=799, sy=524, de=0, hsync=vsync=1. First cycle after release: sx=0, sy=0, de=1, frame_start=1.
- Line timing: run one line -> de=1 for exactly 640 cycles (sx 0..639); hsync=0 exactly for sx 656..751; sx wraps 799->0 and sy increments 0->1 on that same edge.
- Frame timing: run 2 full frames -> vsync low exactly on sy 490..491. frame_start pulses are 420000 cycles apart. frame_count reads 1 after the second frame_start (macro defined) and 0 throughout (macro undefined).
- Stall: deassert en for 5 cycles at sx=639, sy=10 -> all outputs frozen, strobes 0. On re-enable, sx advances 639->640 and de falls to 0.
- Delay alignment with PIPE_DELAY=2 -> de_d rises exactly 2 cycles after de rises at sx=0. With PIPE_DELAY=0 -> de_d==de every cycle.
- Mid-frame reset: assert rst_n=0 for 1 clk at sx=300, sy=200 -> next cycle sx=799, sy=524, all *_d inactive. Counting restarts from sx=0, sy=0.
